// File: rtl/async_fifo_pkg.sv
// Shared types, default parameters and Gray-code helpers for the async FIFO.
package async_fifo_pkg;

  localparam int unsigned DEF_ADDR_W     = 4;
  localparam int unsigned DEF_SYNC_FLOPS = 2;

  // Widest pointer the helpers handle; narrower pointers are zero-extended.
  localparam int unsigned PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Binary to Gray; zero-extended upper bits stay zero.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary; zero-extended upper bits do not disturb the result.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_flop_sync.sv
// Single-bit multi-flop synchronizer into the clk domain.
module async_fifo_flop_sync #(
  parameter int unsigned FLOP_CNT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [FLOP_CNT-1:0] sync_q;

  // Shift the asynchronous input through FLOP_CNT flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[FLOP_CNT-2:0], d};
    end
  end

  assign q = sync_q[FLOP_CNT-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer controller of the async FIFO (write clock domain only).
// Optional overflow checker: define ASYNC_FIFO_WR_OVERFLOW_CHK_EN.
module async_fifo_wr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned SYNC_FLOPS = DEF_SYNC_FLOPS,
  parameter int unsigned AFULL_LVL  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_gray_ptr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W:0]   wr_gray_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow_err
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  // Full when the write Gray pointer equals the read one with its two MSBs inverted.
  localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_W - 1);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rq;
  logic [PTR_W-1:0] rbin_s;
  logic [PTR_W-1:0] level_next;
  logic             accept_c;
  logic             full_next;
  logic             afull_next;

`ifdef ASSERT_ON
  if (!((SYNC_FLOPS == 2) || (SYNC_FLOPS == 3))) begin : g_bad_sync_flops
    $fatal(1, "async_fifo_wr_ctrl: SYNC_FLOPS must be 2 or 3");
  end
  if (!((AFULL_LVL >= 1) && (AFULL_LVL <= (1 << ADDR_W)))) begin : g_bad_afull_lvl
    $fatal(1, "async_fifo_wr_ctrl: AFULL_LVL out of range");
  end
`endif

  // Bring each read Gray pointer bit into the write domain.
  for (genvar i = 0; i < int'(PTR_W); i++) begin : g_rd_sync
    async_fifo_flop_sync #(
      .FLOP_CNT (SYNC_FLOPS)
    ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (rd_gray_ptr[i]),
      .q       (rq[i])
    );
  end

  // Next pointer and flag/level evaluation against the synchronized read pointer.
  always_comb begin
    accept_c   = wr_en & ~full & reset_n;
    wbin_next  = wbin;
    if (accept_c) begin
      wbin_next = wbin + PTR_W'(1);
    end
    wgray_next = PTR_W'(bin2gray(PTR_MAX_W'(wbin_next)));
    rbin_s     = PTR_W'(gray2bin(PTR_MAX_W'(rq)));
    full_next  = (wgray_next == (rq ^ FULL_MASK));
    level_next = wbin_next - rbin_s;
    afull_next = (level_next >= PTR_W'(AFULL_LVL));
  end

  // Pointer, flag and level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin        <= '0;
      wr_gray_ptr <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      wbin        <= wbin_next;
      wr_gray_ptr <= wgray_next;
      full        <= full_next;
      almost_full <= afull_next;
      wr_level    <= level_next;
    end
  end

  assign mem_we    = accept_c;
  assign mem_waddr = wbin[ADDR_W-1:0];

`ifdef ASYNC_FIFO_WR_OVERFLOW_CHK_EN
  // Sticky record of any write attempted while full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
    end else if (wr_en & full) begin
      overflow_err <= 1'b1;
    end
  end

`ifdef ASSERT_ON
  // Flag upstream logic that ignores full.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(wr_en && full))
        else $error("async_fifo_wr_ctrl: write attempted while full");
    end
  end
`endif
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed self-checking bench for async_fifo_wr_ctrl (ADDR_W=2, SYNC_FLOPS=2, AFULL_LVL=3).
module tb_async_fifo_wr_ctrl;

  localparam int unsigned ADDR_W = 2;

  typedef struct packed {
    logic       full;
    logic       afull;
    logic [2:0] level;
    logic [2:0] gray;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] rd_gray_ptr;
  logic       mem_we;
  logic [1:0] mem_waddr;
  logic [2:0] wr_gray_ptr;
  logic       full;
  logic       almost_full;
  logic [2:0] wr_level;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];

  // Reference state: write count, read pointer as seen by the flags, sync stage.
  logic [2:0] m_wbin, m_rq, m_s1, rd_bin;
  logic       m_full, m_ovf;

  async_fifo_wr_ctrl #(
    .ADDR_W     (ADDR_W),
    .SYNC_FLOPS (2),
    .AFULL_LVL  (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_gray_ptr  (rd_gray_ptr),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .wr_gray_ptr  (wr_gray_ptr),
    .full         (full),
    .almost_full  (almost_full),
    .wr_level     (wr_level),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endfunction

  task automatic model_reset();
    m_wbin = '0; m_rq = '0; m_s1 = '0; rd_bin = '0;
    m_full = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_rd(input logic [2:0] b);
    rd_bin      = b;
    rd_gray_ptr = b ^ (b >> 1);
  endtask

  // One clock cycle; called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic we);
    exp_t       e;
    logic       acc;
    logic [2:0] lvl;
    wr_en = we;
    #1;
    acc = we && !m_full;
    chk("mem_we", 8'(mem_we), 8'(acc));
    if (acc) chk("mem_waddr", 8'(mem_waddr), 8'(m_wbin[1:0]));
`ifdef ASYNC_FIFO_WR_OVERFLOW_CHK_EN
    if (we && m_full) m_ovf = 1'b1;
`endif
    if (acc) m_wbin = m_wbin + 3'd1;
    lvl     = m_wbin - m_rq;
    m_full  = (lvl == 3'd4);
    e.full  = m_full;
    e.afull = (lvl >= 3'd3);
    e.level = lvl;
    e.gray  = m_wbin ^ (m_wbin >> 1);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
    m_rq = m_s1;
    m_s1 = rd_bin;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("full",         8'(full),         8'(e.full));
    chk("almost_full",  8'(almost_full),  8'(e.afull));
    chk("wr_level",     8'(wr_level),     8'(e.level));
    chk("wr_gray_ptr",  8'(wr_gray_ptr),  8'(e.gray));
    chk("overflow_err", 8'(overflow_err), 8'(e.ovf));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_full"},  8'(full),         8'h0);
    chk({tag, "_afull"}, 8'(almost_full),  8'h0);
    chk({tag, "_level"}, 8'(wr_level),     8'h0);
    chk({tag, "_gray"},  8'(wr_gray_ptr),  8'h0);
    chk({tag, "_waddr"}, 8'(mem_waddr),    8'h0);
    chk({tag, "_ovf"},   8'(overflow_err), 8'h0);
  endtask

  initial begin
    logic [2:0] prev_gray;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    model_reset();
    set_rd(3'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_all_zero("reset");

    // Fill with read pointer held at 0.
    cycle(1'b1);
    cycle(1'b1);
    chk("afull_after_2", 8'(almost_full), 8'h0);
    cycle(1'b1);
    chk("afull_after_3", 8'(almost_full), 8'h1);
    chk("full_after_3",  8'(full),        8'h0);
    cycle(1'b1);
    chk("full_after_4",  8'(full),        8'h1);
    chk("gray_after_4",  8'(wr_gray_ptr), 8'h6);

    // Write while full is dropped.
    cycle(1'b1);
    chk("gray_hold_full", 8'(wr_gray_ptr), 8'h6);
`ifdef ASYNC_FIFO_WR_OVERFLOW_CHK_EN
    chk("ovf_set", 8'(overflow_err), 8'h1);
`else
    chk("ovf_tied", 8'(overflow_err), 8'h0);
`endif

    // Drain visibility: one read becomes visible on the third edge.
    set_rd(3'd1);
    cycle(1'b0);
    cycle(1'b0);
    chk("drain_full_e2", 8'(full), 8'h1);
    cycle(1'b0);
    chk("drain_full_e3",  8'(full),     8'h0);
    chk("drain_level_e3", 8'(wr_level), 8'h3);

    // Wrap: write, then advance the read pointer to match.
    for (int k = 0; k < 8; k++) begin
      prev_gray = wr_gray_ptr;
      cycle(1'b1);
      chk("wrap_gray_1bit", 8'($countones(prev_gray ^ wr_gray_ptr)), 8'h1);
      set_rd(rd_bin + 3'd1);
      repeat (3) cycle(1'b0);
    end
    chk("wrap_gray_final", 8'(wr_gray_ptr), 8'(3'd4 ^ 3'd2));

    // Reset mid-fill.
    reset_n = 1'b0;
    #10;
    model_reset();
    set_rd(3'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    #2;
    wr_en   = 1'b1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_mem_we", 8'(mem_we), 8'h0);
    model_reset();
    set_rd(3'd0);
    wr_en = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1);
    chk("post_rst_gray", 8'(wr_gray_ptr), 8'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
